// File: rtl/pipe_em_skid_reg.sv
// pipe_em_skid_reg: EX/MEM pipeline register with valid/ready handshake and a
// one-entry skid buffer. The execute-side ready comes straight from a flop, so
// a memory-stage stall never forms a combinational path back into execute.
// A synchronous flush squashes both held entries. Bubbles present m_ctrl = 0.
// Optional feature: define PIPE_EM_FWD_EN to add the EX/MEM forwarding ports
// (fwd_rs, fwd_hit, fwd_data), which look only at the main register.
module pipe_em_skid_reg #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int CTRL_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              e_valid,
    output logic              e_ready,
    input  logic [CTRL_W-1:0] e_ctrl,
    input  logic [DATA_W-1:0] e_alu,
    input  logic [DATA_W-1:0] e_b,
    input  logic [RN_W-1:0]   e_rn,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [DATA_W-1:0] m_alu,
    output logic [DATA_W-1:0] m_b,
    output logic [RN_W-1:0]   m_rn
`ifdef PIPE_EM_FWD_EN
    ,
    input  logic [RN_W-1:0]   fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // Main (output-facing) register.
    logic              m_valid_r;
    logic [CTRL_W-1:0] m_ctrl_r;
    logic [DATA_W-1:0] m_alu_r;
    logic [DATA_W-1:0] m_b_r;
    logic [RN_W-1:0]   m_rn_r;

    // Skid register: catches the entry accepted in the first stall cycle.
    logic              s_valid_r;
    logic [CTRL_W-1:0] s_ctrl_r;
    logic [DATA_W-1:0] s_alu_r;
    logic [DATA_W-1:0] s_b_r;
    logic [RN_W-1:0]   s_rn_r;

    // Handshake decode.
    logic in_xfer_s;
    logic main_load_s;
    logic skid_load_s;
    logic skid_drain_s;

    // Transfer and load-enable decode; ready depends only on the skid flop.
    always_comb begin
        in_xfer_s    = 1'b0;
        main_load_s  = 1'b0;
        skid_load_s  = 1'b0;
        skid_drain_s = 1'b0;
        in_xfer_s    = e_valid & ~s_valid_r;
        main_load_s  = ~m_valid_r | m_ready;
        // Input goes to skid when main cannot take it directly: main is
        // stalled, or main is refilling from skid this cycle.
        skid_load_s  = in_xfer_s & (~main_load_s | s_valid_r);
        skid_drain_s = main_load_s & s_valid_r;
    end

    // Main register: flush squashes, otherwise skid has priority over input
    // so ordering is preserved; payload only changes on a load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_valid_r <= 1'b0;
            m_ctrl_r  <= {CTRL_W{1'b0}};
            m_alu_r   <= {DATA_W{1'b0}};
            m_b_r     <= {DATA_W{1'b0}};
            m_rn_r    <= {RN_W{1'b0}};
        end else if (flush) begin
            m_valid_r <= 1'b0;
        end else if (main_load_s) begin
            if (s_valid_r) begin
                m_valid_r <= 1'b1;
                m_ctrl_r  <= s_ctrl_r;
                m_alu_r   <= s_alu_r;
                m_b_r     <= s_b_r;
                m_rn_r    <= s_rn_r;
            end else if (in_xfer_s) begin
                m_valid_r <= 1'b1;
                m_ctrl_r  <= e_ctrl;
                m_alu_r   <= e_alu;
                m_b_r     <= e_b;
                m_rn_r    <= e_rn;
            end else begin
                m_valid_r <= 1'b0;
            end
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    // Skid register: fills on a blocked input transfer, empties when main
    // takes its contents; a refill in the drain cycle cannot occur because
    // e_ready is low whenever the skid is occupied.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_valid_r <= 1'b0;
            s_ctrl_r  <= {CTRL_W{1'b0}};
            s_alu_r   <= {DATA_W{1'b0}};
            s_b_r     <= {DATA_W{1'b0}};
            s_rn_r    <= {RN_W{1'b0}};
        end else if (flush) begin
            s_valid_r <= 1'b0;
        end else if (skid_load_s) begin
            s_valid_r <= 1'b1;
            s_ctrl_r  <= e_ctrl;
            s_alu_r   <= e_alu;
            s_b_r     <= e_b;
            s_rn_r    <= e_rn;
        end else if (skid_drain_s) begin
            s_valid_r <= 1'b0;
        end else begin
            s_valid_r <= s_valid_r;
        end
    end

    assign e_ready = ~s_valid_r;
    assign m_valid = m_valid_r;
    // Bubbles never carry write-type control.
    assign m_ctrl  = m_ctrl_r & {CTRL_W{m_valid_r}};
    assign m_alu   = m_alu_r;
    assign m_b     = m_b_r;
    assign m_rn    = m_rn_r;

`ifdef PIPE_EM_FWD_EN
    // Forward a non-load ALU result from the main register; r0 never matches.
    assign fwd_hit  = m_valid_r & m_ctrl_r[0] & ~m_ctrl_r[1]
                    & (m_rn_r == fwd_rs) & (m_rn_r != {RN_W{1'b0}});
    assign fwd_data = m_alu_r;
`endif

endmodule

// File: tb/tb_pipe_em_skid_reg.sv
// Directed scoreboard bench for pipe_em_skid_reg. Entries accepted by the
// handshake (as predicted by an occupancy model) are queued; the queue head is
// what the main register must present, and it is popped on consumption.
module tb_pipe_em_skid_reg;

    localparam int DATA_W = 32;
    localparam int RN_W   = 5;
    localparam int CTRL_W = 3;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
        logic [RN_W-1:0]   rn;
    } entry_t;

    logic              clock = 1'b0;
    logic              resetn;
    logic              e_valid;
    logic              e_ready;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_alu;
    logic [DATA_W-1:0] e_b;
    logic [RN_W-1:0]   e_rn;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_alu;
    logic [DATA_W-1:0] m_b;
    logic [RN_W-1:0]   m_rn;
`ifdef PIPE_EM_FWD_EN
    logic [RN_W-1:0]   fwd_rs;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    entry_t q[$];

    pipe_em_skid_reg #(.DATA_W(DATA_W), .RN_W(RN_W), .CTRL_W(CTRL_W)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .e_valid (e_valid),
        .e_ready (e_ready),
        .e_ctrl  (e_ctrl),
        .e_alu   (e_alu),
        .e_b     (e_b),
        .e_rn    (e_rn),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ctrl  (m_ctrl),
        .m_alu   (m_alu),
        .m_b     (m_b),
        .m_rn    (m_rn)
`ifdef PIPE_EM_FWD_EN
        ,
        .fwd_rs  (fwd_rs),
        .fwd_hit (fwd_hit),
        .fwd_data(fwd_data)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                         input logic [RN_W-1:0] r, input logic mr, input logic fl);
        e_valid = v;
        e_ctrl  = c;
        e_alu   = a;
        e_b     = ~a;
        e_rn    = r;
        m_ready = mr;
        flush   = fl;
    endtask

    // Compare outputs against the queue head (or a bubble when empty).
    task automatic check_out(input string tag);
        chk({tag, ":m_valid"}, 64'(m_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk({tag, ":m_ctrl"}, 64'(m_ctrl), 64'(q[0].ctrl));
            chk({tag, ":m_alu"},  64'(m_alu),  64'(q[0].alu));
            chk({tag, ":m_b"},    64'(m_b),    64'(q[0].b));
            chk({tag, ":m_rn"},   64'(m_rn),   64'(q[0].rn));
        end else begin
            chk({tag, ":m_ctrl_bubble"}, 64'(m_ctrl), 64'(0));
        end
    endtask

    // One clock: check ready, predict transfers, advance model, check outputs.
    task automatic cycle(input string tag);
        logic   in_x;
        logic   out_x;
        entry_t ent;
        chk({tag, ":e_ready"}, 64'(e_ready), 64'(q.size() < 2));
        in_x  = e_valid && (q.size() < 2) && !flush;
        out_x = (q.size() > 0) && m_ready;
        ent   = '{ctrl: e_ctrl, alu: e_alu, b: e_b, rn: e_rn};
        @(posedge clock);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (out_x) q.delete(0);
            if (in_x) q.push_back(ent);
        end
        check_out(tag);
    endtask

    initial begin
        // Reset with random inputs.
        resetn = 1'b0;
        drive(1'b1, 3'($urandom()), $urandom(), 5'($urandom()), 1'b0, 1'b0);
        @(posedge clock);
        drive(1'b1, 3'($urandom()), $urandom(), 5'($urandom()), 1'b1, 1'b0);
        @(posedge clock);
        #1;
        chk("rst:m_valid", 64'(m_valid), 64'(0));
        chk("rst:m_ctrl",  64'(m_ctrl),  64'(0));
        chk("rst:m_alu",   64'(m_alu),   64'(0));
        chk("rst:m_b",     64'(m_b),     64'(0));
        chk("rst:m_rn",    64'(m_rn),    64'(0));
        chk("rst:e_ready", 64'(e_ready), 64'(1));
        resetn = 1'b1;

        // First entry after reset.
        drive(1'b1, 3'b001, 32'h1234_5678, 5'd3, 1'b1, 1'b0);
        cycle("first");
        chk("first:alu_const", 64'(m_alu), 64'h1234_5678);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle("first_drain");

        // Streaming at full throughput.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 3'(i), 32'(i), 5'(i), 1'b1, 1'b0);
            cycle("stream");
            chk("stream:alu_seq", 64'(m_alu), 64'(i));
        end
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle("stream_drain");

        // Stall into skid, then release in order.
        drive(1'b1, 3'b101, 32'd10, 5'd10, 1'b1, 1'b0);
        cycle("stall10");
        drive(1'b1, 3'b110, 32'd11, 5'd11, 1'b0, 1'b0);
        cycle("stall11");
        drive(1'b1, 3'b111, 32'd12, 5'd12, 1'b0, 1'b0);
        cycle("stall12a");
        chk("stall:ready_low", 64'(e_ready), 64'(0));
        cycle("stall12b");
        chk("stall:hold10", 64'(m_alu), 64'(10));
        m_ready = 1'b1;
        cycle("rel11");
        chk("rel:alu11", 64'(m_alu), 64'(11));
        cycle("rel12");
        chk("rel:alu12", 64'(m_alu), 64'(12));
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle("rel_drain");
        chk("rel:empty", 64'(m_valid), 64'(0));

        // Flush with both entries held and an input offered.
        drive(1'b1, 3'b111, 32'd20, 5'd20, 1'b0, 1'b0);
        cycle("fl20");
        drive(1'b1, 3'b111, 32'd21, 5'd21, 1'b0, 1'b0);
        cycle("fl21");
        drive(1'b1, 3'b111, 32'd22, 5'd22, 1'b0, 1'b1);
        cycle("flush");
        chk("flush:m_valid", 64'(m_valid), 64'(0));
        chk("flush:e_ready", 64'(e_ready), 64'(1));
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle("flush_after1");
        cycle("flush_after2");

        // Flush coinciding with consumption of a single entry.
        drive(1'b1, 3'b001, 32'd23, 5'd23, 1'b1, 1'b0);
        cycle("fl23");
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b1);
        cycle("flush_mready");
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle("flush_mready_after");

        // Asynchronous reset with two entries held.
        drive(1'b1, 3'b111, 32'd30, 5'd30, 1'b0, 1'b0);
        cycle("ar30");
        drive(1'b1, 3'b111, 32'd31, 5'd31, 1'b0, 1'b0);
        cycle("ar31");
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        q.delete();
        chk("arst:m_valid", 64'(m_valid), 64'(0));
        chk("arst:m_ctrl",  64'(m_ctrl),  64'(0));
        chk("arst:m_alu",   64'(m_alu),   64'(0));
        chk("arst:m_b",     64'(m_b),     64'(0));
        chk("arst:m_rn",    64'(m_rn),    64'(0));
        chk("arst:e_ready", 64'(e_ready), 64'(1));
        #2;
        resetn = 1'b1;
        drive(1'b1, 3'b010, 32'd40, 5'd7, 1'b1, 1'b0);
        cycle("post_arst");
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle("post_arst_drain");

`ifdef PIPE_EM_FWD_EN
        drive(1'b1, 3'b001, 32'hAA, 5'd5, 1'b0, 1'b0);
        cycle("fwd_load");
        fwd_rs = 5'd5;
        #1;
        chk("fwd:hit",  64'(fwd_hit),  64'(1));
        chk("fwd:data", 64'(fwd_data), 64'hAA);
        fwd_rs = 5'd6;
        #1;
        chk("fwd:miss_rs", 64'(fwd_hit), 64'(0));
        drive(1'b1, 3'b011, 32'hBB, 5'd5, 1'b1, 1'b0);
        cycle("fwd_ld");
        fwd_rs = 5'd5;
        #1;
        chk("fwd:load", 64'(fwd_hit), 64'(0));
        drive(1'b1, 3'b001, 32'hCC, 5'd0, 1'b1, 1'b0);
        cycle("fwd_r0");
        fwd_rs = 5'd0;
        #1;
        chk("fwd:r0", 64'(fwd_hit), 64'(0));
        drive(1'b0, 3'b001, 32'h0, 5'd5, 1'b1, 1'b0);
        cycle("fwd_empty");
        fwd_rs = 5'd5;
        #1;
        chk("fwd:empty", 64'(fwd_hit), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
